// File: rtl/mux_serial_pkg.sv
// Shared types and frame helpers for the mux_serial_tx sampler/serialiser.
// Define MUX_SERIAL_PARITY_EN to insert an even-parity bit before the stop bit.
package mux_serial_pkg;

`ifdef MUX_SERIAL_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, MUX, SOC, WAIT_EOC, LOAD, CHECK, TX, NEXT} state_t;

   typedef enum logic [1:0] {START, DATA, PARITY, STOP} frame_pos_t;

   function automatic int unsigned frame_bits(input int unsigned data_w, input bit parity);
      return data_w + 32'd2 + 32'(parity);
   endfunction

   function automatic frame_pos_t frame_pos(input int unsigned idx, input int unsigned data_w,
                                            input bit parity);
      if (idx == 0) return START;
      if (idx <= data_w) return DATA;
      if (parity && idx == data_w + 1) return PARITY;
      return STOP;
   endfunction

endpackage

// File: rtl/mux_serial_shifter.sv
// Serial frame generator: bit-period divider, frame bit counter, MSB-first shift register.
// Parity bit is included when MUX_SERIAL_PARITY_EN is defined.
module mux_serial_shifter
   import mux_serial_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned BIT_DIV = 104
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] word,
   output logic              line,
   output logic              done
);

   localparam int unsigned NBITS = frame_bits(DATA_W, PARITY_EN);
   localparam int unsigned DIV_W = $clog2(BIT_DIV);
   localparam int unsigned BC_W  = $clog2(NBITS);

   logic [DIV_W-1:0]  div;
   logic [BC_W-1:0]   bit_cnt;
   logic [DATA_W-1:0] sreg;
   logic              par;
   logic              active;
   logic              bit_end;
   logic              last_bit;
   frame_pos_t        next_pos;

   assign bit_end  = active && (div == DIV_W'(BIT_DIV - 1));
   assign last_bit = (bit_cnt == BC_W'(NBITS - 1));
   assign done     = bit_end && last_bit;
   assign next_pos = frame_pos(32'(bit_cnt) + 32'd1, DATA_W, PARITY_EN);

   // line is only ever written at a bit boundary or on frame start
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         active  <= 1'b0;
         line    <= 1'b1;
         div     <= '0;
         bit_cnt <= '0;
         sreg    <= '0;
         par     <= 1'b0;
      end else if (!active) begin
         if (start) begin
            active  <= 1'b1;
            line    <= 1'b0;
            div     <= '0;
            bit_cnt <= '0;
            sreg    <= word;
            par     <= ^word;
         end
      end else if (bit_end) begin
         div <= '0;
         if (last_bit) begin
            active  <= 1'b0;
            line    <= 1'b1;
            bit_cnt <= '0;
         end else begin
            bit_cnt <= bit_cnt + 1'b1;
            case (next_pos)
               DATA: begin
                  line <= sreg[DATA_W-1];
                  sreg <= {sreg[DATA_W-2:0], 1'b0};
               end
               PARITY:  line <= par;
               default: line <= 1'b1;
            endcase
         end
      end else begin
         div <= div + 1'b1;
      end
   end

endmodule

// File: rtl/mux_serial_tx.sv
// Round-robin ADC sampler and serial transmitter: sequencer FSM, channel counter, sample hold.
// Optional parity selected by MUX_SERIAL_PARITY_EN (see mux_serial_pkg).
module mux_serial_tx
   import mux_serial_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned NUM_CH  = 8,
   parameter int unsigned BIT_DIV = 104,
   localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic              eoc,
   input  logic [DATA_W-1:0] data_in,
   input  logic              dsr,
   output logic              mux_en,
   output logic [CH_W-1:0]   canale,
   output logic              soc,
   output logic              load_dato,
   output logic              data_out,
   output logic              busy,
   output logic              error,
   output logic              tx_done
);

   state_t            state;
   logic [DATA_W-1:0] hold;
   logic              shift_start;
   logic              shift_done;

   assign shift_start = (state == CHECK) && dsr;

   mux_serial_shifter #(
      .DATA_W  (DATA_W),
      .BIT_DIV (BIT_DIV)
   ) u_shifter (
      .clock (clock),
      .reset (reset),
      .start (shift_start),
      .word  (hold),
      .line  (data_out),
      .done  (shift_done)
   );

   // Outputs are set on the transition into each state so they track the state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         hold      <= '0;
         mux_en    <= 1'b0;
         soc       <= 1'b0;
         load_dato <= 1'b0;
         canale    <= '0;
         busy      <= 1'b0;
         error     <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (run) begin
               state  <= MUX;
               mux_en <= 1'b1;
               busy   <= 1'b1;
            end
            MUX: begin
               state <= SOC;
               soc   <= 1'b1;
            end
            SOC: state <= WAIT_EOC;
            WAIT_EOC: if (!eoc) begin
               hold      <= data_in;
               state     <= LOAD;
               mux_en    <= 1'b0;
               soc       <= 1'b0;
               load_dato <= 1'b1;
            end
            LOAD: begin
               state     <= CHECK;
               load_dato <= 1'b0;
            end
            CHECK: if (dsr) begin
               state <= TX;
               error <= 1'b0;
            end else begin
               error <= 1'b1;
            end
            TX: if (shift_done) begin
               state   <= NEXT;
               tx_done <= 1'b1;
               canale  <= (canale == CH_W'(NUM_CH - 1)) ? '0 : canale + 1'b1;
            end
            NEXT: begin
               tx_done <= 1'b0;
               if (run) begin
                  state  <= MUX;
                  mux_en <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_serial_tx.sv
// Self-checking bench for mux_serial_tx (DATA_W=8, NUM_CH=3, BIT_DIV=4).
// Expected waveforms come from a per-frame timeline built from the frame bit list.
module tb_mux_serial_tx;

   localparam int DW  = 8;
   localparam int NCH = 3;
   localparam int BD  = 4;
`ifdef MUX_SERIAL_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          run;
   logic          eoc;
   logic [DW-1:0] data_in;
   logic          dsr;
   logic          mux_en;
   logic [1:0]    canale;
   logic          soc;
   logic          load_dato;
   logic          data_out;
   logic          busy;
   logic          error;
   logic          tx_done;

   int checks = 0;
   int errors = 0;
   int ch     = 0;

   mux_serial_tx #(
      .DATA_W  (DW),
      .NUM_CH  (NCH),
      .BIT_DIV (BD)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .run       (run),
      .eoc       (eoc),
      .data_in   (data_in),
      .dsr       (dsr),
      .mux_en    (mux_en),
      .canale    (canale),
      .soc       (soc),
      .load_dato (load_dato),
      .data_out  (data_out),
      .busy      (busy),
      .error     (error),
      .tx_done   (tx_done)
   );

   always #5 clock = ~clock;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, ".mux_en"}, -1, 32'(mux_en), 0);
      chk({tag, ".soc"}, -1, 32'(soc), 0);
      chk({tag, ".load_dato"}, -1, 32'(load_dato), 0);
      chk({tag, ".canale"}, -1, 32'(canale), 0);
      chk({tag, ".data_out"}, -1, 32'(data_out), 1);
      chk({tag, ".busy"}, -1, 32'(busy), 0);
      chk({tag, ".error"}, -1, 32'(error), 0);
      chk({tag, ".tx_done"}, -1, 32'(tx_done), 0);
   endtask

   // Caller guarantees the next clock edge enters MUX. Cycle 0 = MUX, k WAIT_EOC cycles,
   // stall extra CHECK cycles; abort_at >= 0 fires an asynchronous reset at that cycle.
   task automatic do_frame(input logic [DW-1:0] data, input int k, input int stall,
                           input bit next_run, input int abort_at);
      logic fb[$];
      int   L;
      int   F;
      int   T;
      logic exp_line;
      fb = {};
      fb.push_back(1'b0);
      for (int i = DW - 1; i >= 0; i--) fb.push_back(data[i]);
      if (PAR) fb.push_back(^data);
      fb.push_back(1'b1);
      F = fb.size() * BD;
      L = 4 + k + stall;
      T = L + F;
      for (int c = 0; c <= T; c++) begin
         tick();
         chk("mux_en", c, 32'(mux_en), 32'(c <= 1 + k));
         chk("soc", c, 32'(soc), 32'(c >= 1 && c <= 1 + k));
         chk("load_dato", c, 32'(load_dato), 32'(c == 2 + k));
         chk("busy", c, 32'(busy), 1);
         chk("tx_done", c, 32'(tx_done), 32'(c == T));
         chk("error", c, 32'(error), 32'(stall > 0 && c >= 4 + k && c <= 3 + k + stall));
         chk("canale", c, 32'(canale), (c == T) ? (ch + 1) % NCH : ch);
         exp_line = (c >= L && c < T) ? fb[(c - L) / BD] : 1'b1;
         chk("data_out", c, 32'(data_out), 32'(exp_line));
         if (c == abort_at) begin
            #1 reset = 1'b1;
            #1 chk_reset_values("async_reset");
            run = 1'b1;
            tick();
            chk_reset_values("reset_held");
            reset = 1'b0;
            ch = 0;
            return;
         end
         eoc     = (c == 1 + k) ? 1'b0 : (c >= L ? 1'($urandom_range(0, 1)) : 1'b1);
         data_in = (c == 1 + k) ? data : DW'($urandom);
         if (c >= 3 + k && c < 3 + k + stall) dsr = 1'b0;
         else if (c == 3 + k + stall)         dsr = 1'b1;
         else                                 dsr = 1'($urandom_range(0, 1));
         if (!next_run && c == L + 2) run = 1'b0;
         if (c == T) run = next_run;
      end
      ch = (ch + 1) % NCH;
   endtask

   initial begin
      reset   = 1'b1;
      run     = 1'b0;
      eoc     = 1'b1;
      dsr     = 1'b1;
      data_in = '0;
      tick();
      tick();
      chk_reset_values("reset");
      reset = 1'b0;
      tick();
      tick();
      chk("idle.busy", 0, 32'(busy), 0);
      chk("idle.mux_en", 0, 32'(mux_en), 0);

      run = 1'b1;
      do_frame(8'hA5, 3, 0, 1'b1, -1);
      do_frame(DW'($urandom), $urandom_range(1, 4), 0, 1'b1, -1);
      do_frame(DW'($urandom), $urandom_range(1, 4), 0, 1'b1, -1);
      do_frame(DW'($urandom), 2, 10, 1'b1, -1);
      do_frame(8'h07, 1, 0, 1'b1, -1);
      do_frame(8'h03, 2, 0, 1'b1, -1);
      for (int n = 0; n < 3; n++)
         do_frame(DW'($urandom), $urandom_range(1, 5), $urandom_range(0, 3), 1'b1, -1);

      // Abort in the fourth data bit, then the next conversion must start on channel 0.
      do_frame(DW'($urandom), 2, 0, 1'b1, 4 + 2 + 4 * BD + 1);
      do_frame(DW'($urandom), 1, 0, 1'b1, -1);

      // run drops mid-frame: frame completes and the sequencer parks in IDLE.
      do_frame(DW'($urandom), 2, 1, 1'b0, -1);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("stop.busy", i, 32'(busy), 0);
         chk("stop.soc", i, 32'(soc), 0);
         chk("stop.mux_en", i, 32'(mux_en), 0);
         chk("stop.tx_done", i, 32'(tx_done), 0);
         chk("stop.data_out", i, 32'(data_out), 1);
         chk("stop.canale", i, 32'(canale), ch);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_serial_tx.md
# mux_serial_tx

Round-robin sampler and serial transmitter: steps an analog multiplexer through `NUM_CH` channels and runs one ADC conversion per channel via the soc/eoc handshake. Each `DATA_W`-bit sample is captured and sent as an asynchronous serial frame gated by `dsr`, with an error flag. It is the parametrised successor of the fixed 8-bit, 8-channel sampler/serialiser in the ITC-style test designs. It adds a run control, a generic bit period and optional parity.

## Interface
Parameters:
- `DATA_W`, 8: sample width; bits sent MSB first.
- `NUM_CH`, 8: channel count, ≥2.
- `BIT_DIV`, 104: clock cycles per serial bit, ≥2.
- Localparam `CH_W` = $clog2(`NUM_CH`).
- Localparam `DIV_W` = $clog2(`BIT_DIV`).

Ports:
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `run` input 1: enables sequencing.
- `eoc` input 1: ADC busy; conversion complete when low.
- `data_in` input `DATA_W`: ADC result.
- `dsr` input 1: receiver ready.
- `mux_en` output 1: multiplexer enable.
- `canale` output `CH_W`: selected channel.
- `soc` output 1: start of conversion.
- `load_dato` output 1: sample-capture strobe.
- `data_out` output 1: serial line; idles high.
- `busy` output 1: high in every state except IDLE.
- `error` output 1: dsr-not-ready flag.
- `tx_done` output 1: one-cycle frame-complete pulse.

## Operation
- States: IDLE, MUX, SOC, WAIT_EOC, LOAD, CHECK, TX, NEXT. All outputs are registered.
- IDLE → MUX when `run`=1.
- MUX: `mux_en`=1 for one cycle.
- SOC: `mux_en`=1, `soc`=1 for one cycle.
- WAIT_EOC: `mux_en`=1, `soc`=1. Stays while `eoc`=1. On the edge that samples `eoc`=0, `data_in` goes into the hold register and the FSM moves to LOAD.
- LOAD: `load_dato`=1 and `mux_en`=0 for one cycle.
- CHECK: if `dsr`=1, go to TX and clear `error`. If `dsr`=0, set `error`=1 and stay in CHECK; the sample stays held and `data_out`=1.
- TX: shifter sends the start bit (0), `DATA_W` data bits MSB first, the optional parity bit, then the stop bit (1). Each bit lasts exactly `BIT_DIV` cycles. `dsr` is ignored mid-frame. `data_in`/`eoc` changes do not affect the frame.
- NEXT: one cycle. `tx_done`=1. `canale` increments, wrapping from `NUM_CH`-1 to 0. Then go to MUX if `run`=1, else IDLE.
- `run`=0 takes effect only in IDLE or NEXT; a conversion or frame in progress always completes.

## Timing
- Reset values: `mux_en`=0, `soc`=0, `load_dato`=0, `canale`=0, `data_out`=1, `busy`=0, `error`=0, `tx_done`=0. State = IDLE; bit and divider counters = 0.
- Reset asserted mid-frame or mid-conversion: outputs take reset values immediately, with no clock needed. The partial frame is abandoned; there is no stop-bit completion.
- Latency from MUX entry to start-bit edge: 4 + k cycles, where k ≥ 1 is the number of WAIT_EOC cycles; add cycles spent stalled in CHECK.
- Frame duration: F = (`DATA_W`+2) × `BIT_DIV` cycles, or (`DATA_W`+3) × `BIT_DIV` with parity.
- `tx_done` rises in the cycle after the last stop-bit cycle.
- `data_out` changes only on bit boundaries. The divider counts 0..`BIT_DIV`-1 and never overflows `DIV_W`.

## Configuration
- `MUX_SERIAL_PARITY_EN` defined: an even-parity bit (XOR of all data bits) is inserted between the last data bit and the stop bit.
- `MUX_SERIAL_PARITY_EN` undefined: no parity bit; the frame has `DATA_W`+2 bits.

## Structure
- Package `mux_serial_pkg` holds:
  - the state enum;
  - the frame-position constants START, DATA, PARITY and STOP;
  - a function returning frame bit count from `DATA_W` and the parity setting.
- Sub-module `mux_serial_shifter` contains the divider, bit counter, shift register and parity generator. Its handshake is `start` in (with word) and `done` out.
- The top level keeps the sequencer FSM and the channel counter.

## Test plan
All scenarios use `DATA_W`=8, `NUM_CH`=3, `BIT_DIV`=4.
- Basic frame: `run`=1, `eoc` held 1 for 2 WAIT_EOC cycles then 0, `data_in`=0xA5, `dsr`=1 → start bit 0, then 1,0,1,0,0,1,0,1, then stop 1, each bit 4 cycles; `tx_done` pulses once; `canale` 0→1.
- Wrap: three consecutive frames → `canale` sequence 0, 1, 2, 0; `mux_en` high in MUX/SOC/WAIT_EOC only.
- Flow control: `dsr`=0 at CHECK for 10 cycles → `error`=1 and `data_out`=1 throughout; on `dsr`=1 → `error` clears and the held sample (not the new `data_in`) is sent.
- Parity, with `MUX_SERIAL_PARITY_EN`: 0x07 → parity bit 1; 0x03 → parity bit 0; frame length 44 cycles.
- Async reset during data bit 3 → all outputs at reset values before the next edge; after release with `run`=1, the next conversion uses `canale`=0.
- Stop request: `run` dropped mid-frame → frame completes, `tx_done` pulses, state returns to IDLE, `busy`=0 and `soc` stays 0.
